// File: rtl/telem_pkg.sv
// telem_pkg: shared FSM states, default sizes and coordinate record for the track file
package telem_pkg;

    localparam int DEF_NUM_TGT = 16;
    localparam int DEF_CRD_W   = 8;
    localparam int DEF_AGE_W   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_CRD_W-1:0] x;
        logic [DEF_CRD_W-1:0] y;
        logic [DEF_CRD_W-1:0] z;
        logic [DEF_CRD_W-1:0] t;
    } coord_t;

endpackage

// File: rtl/telem_entry.sv
// telem_entry: one track-file slot holding payload, valid flag and saturating age
module telem_entry
    import telem_pkg::*;
#(
    parameter int PAY_W = 4 * DEF_CRD_W,
    parameter int AGE_W = DEF_AGE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             clr,
    input  logic             tick,
    input  logic [PAY_W-1:0] din,
    output logic [PAY_W-1:0] q,
    output logic             valid,
    output logic [AGE_W-1:0] age
);

    // clear beats write beats aging, so a write in a tick cycle restarts age at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
            age   <= '0;
        end else if (clr) begin
            q     <= '0;
            valid <= 1'b0;
            age   <= '0;
        end else if (we) begin
            q     <= din;
            valid <= 1'b1;
            age   <= '0;
        end else if (tick && valid && !(&age)) begin
            age <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/telem_track_file.sv
// telem_track_file: indexed target track file with 1-cycle reads, aging and a sweeping clear
module telem_track_file
    import telem_pkg::*;
#(
    parameter int NUM_TGT = DEF_NUM_TGT,
    parameter int CRD_W   = DEF_CRD_W,
    parameter int AGE_W   = DEF_AGE_W,
    parameter int SEL_W   = $clog2(NUM_TGT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [SEL_W-1:0]   wr_sel,
    input  logic [CRD_W-1:0]   wr_x,
    input  logic [CRD_W-1:0]   wr_y,
    input  logic [CRD_W-1:0]   wr_z,
    input  logic [CRD_W-1:0]   wr_t,
    input  logic               rd_req,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic               rd_valid,
    output logic [CRD_W-1:0]   rd_x,
    output logic [CRD_W-1:0]   rd_y,
    output logic [CRD_W-1:0]   rd_z,
    output logic [CRD_W-1:0]   rd_t,
    output logic               rd_hit,
    output logic [AGE_W-1:0]   rd_age,
    input  logic               age_tick,
    input  logic               clr_req,
    output logic               clr_busy,
    output logic [NUM_TGT-1:0] valid_mask,
    output logic [NUM_TGT-1:0] stale_mask,
    output logic               err
);

    localparam int PAY_W = 4 * CRD_W;

    state_t             state;
    logic [SEL_W-1:0]   idx;
    logic [NUM_TGT-1:0] we;
    logic [NUM_TGT-1:0] cl;
    logic [PAY_W-1:0]   q   [NUM_TGT];
    logic [AGE_W-1:0]   age [NUM_TGT];
    logic [PAY_W-1:0]   rd_q;
    logic [AGE_W-1:0]   rd_a;
    logic               rd_v;
    logic               wr_ok;
    logic               rd_ok;

    assign wr_ready = state == IDLE;
    assign clr_busy = state == CLEAR;
    assign wr_ok    = 32'(wr_sel) < NUM_TGT;
    assign rd_ok    = 32'(rd_sel) < NUM_TGT;

    for (genvar i = 0; i < NUM_TGT; i++) begin : g_ent
        assign we[i]         = wr_valid && wr_ready && wr_sel == SEL_W'(i);
        assign cl[i]         = clr_busy && idx == SEL_W'(i);
        assign stale_mask[i] = valid_mask[i] && (&age[i]);
        telem_entry #(
            .PAY_W(PAY_W),
            .AGE_W(AGE_W)
        ) u_ent (
            .clk  (clk),
            .rst  (rst),
            .we   (we[i]),
            .clr  (cl[i]),
            .tick (age_tick),
            .din  ({wr_x, wr_y, wr_z, wr_t}),
            .q    (q[i]),
            .valid(valid_mask[i]),
            .age  (age[i])
        );
    end

    // select the addressed entry; an out-of-range index matches nothing and reads as empty
    always_comb begin
        rd_q = '0;
        rd_a = '0;
        rd_v = 1'b0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_q = q[i];
                rd_a = age[i];
                rd_v = valid_mask[i];
            end
        end
    end

    // sweep one entry per cycle from 0 to NUM_TGT-1, ignoring clr_req while sweeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else if (state == IDLE) begin
            state <= clr_req ? CLEAR : IDLE;
            idx   <= '0;
        end else begin
            state <= idx == SEL_W'(NUM_TGT - 1) ? IDLE : CLEAR;
            idx   <= idx + SEL_W'(1);
        end
    end

    // register read response from pre-edge contents; payload holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid                 <= 1'b0;
            rd_hit                   <= 1'b0;
            rd_age                   <= '0;
            {rd_x, rd_y, rd_z, rd_t} <= '0;
            err                      <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            err      <= (wr_valid && wr_ready && !wr_ok) || (rd_req && !rd_ok);
            if (rd_req) begin
                rd_hit                   <= rd_v;
                rd_age                   <= rd_v ? rd_a : '0;
                {rd_x, rd_y, rd_z, rd_t} <= rd_v ? rd_q : '0;
            end
        end
    end

endmodule

// File: tb/tb_telem_track_file.sv
// tb_telem_track_file: directed scoreboard bench for the track file (16- and 12-entry builds)
module tb_telem_track_file;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        wr_valid = 1'b0, rd_req = 1'b0, age_tick = 1'b0, clr_req = 1'b0;
    logic [3:0]  wr_sel = '0, rd_sel = '0;
    logic [7:0]  wr_x = '0, wr_y = '0, wr_z = '0, wr_t = '0;
    logic        wr_ready, rd_valid, rd_hit, clr_busy, err;
    logic [7:0]  rd_x, rd_y, rd_z, rd_t;
    logic [3:0]  rd_age;
    logic [15:0] valid_mask, stale_mask;

    logic        b_wr_valid = 1'b0, b_rd_req = 1'b0;
    logic [3:0]  b_wr_sel = '0, b_rd_sel = '0;
    logic [7:0]  b_wr_x = '0;
    logic        b_wr_ready, b_rd_valid, b_rd_hit, b_clr_busy, b_err;
    logic [7:0]  b_rd_x, b_rd_y, b_rd_z, b_rd_t;
    logic [3:0]  b_rd_age;
    logic [11:0] b_valid_mask, b_stale_mask;

    logic [36:0] exp_q[$];
    logic [36:0] exp_b[$];

    telem_track_file #(.NUM_TGT(16), .CRD_W(8), .AGE_W(4)) u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
        .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_t(wr_t), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z), .rd_t(rd_t),
        .rd_hit(rd_hit), .rd_age(rd_age), .age_tick(age_tick), .clr_req(clr_req),
        .clr_busy(clr_busy), .valid_mask(valid_mask), .stale_mask(stale_mask), .err(err)
    );

    telem_track_file #(.NUM_TGT(12), .CRD_W(8), .AGE_W(4)) u_dut12 (
        .clk(clk), .rst(rst), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_sel(b_wr_sel),
        .wr_x(b_wr_x), .wr_y(8'h11), .wr_z(8'h22), .wr_t(8'h33), .rd_req(b_rd_req), .rd_sel(b_rd_sel),
        .rd_valid(b_rd_valid), .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_z(b_rd_z), .rd_t(b_rd_t),
        .rd_hit(b_rd_hit), .rd_age(b_rd_age), .age_tick(1'b0), .clr_req(1'b0),
        .clr_busy(b_clr_busy), .valid_mask(b_valid_mask), .stale_mask(b_stale_mask), .err(b_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [36:0] ex(input logic h, input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] z, input logic [7:0] t, input logic [3:0] a);
        return {h, x, y, z, t, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] z, input logic [7:0] t);
        wr_valid = 1'b1; wr_sel = s; wr_x = x; wr_y = y; wr_z = z; wr_t = t;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] s, input logic [36:0] e);
        rd_req = 1'b1; rd_sel = s;
        exp_q.push_back(e);
        step();
        rd_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            chk("rd_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("rd_data", {rd_hit, rd_x, rd_y, rd_z, rd_t, rd_age}, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_rd_valid) begin
            chk("b_rd_pending", 64'(exp_b.size() != 0), 64'd1);
            if (exp_b.size() != 0) chk("b_rd_data", {b_rd_hit, b_rd_x, b_rd_y, b_rd_z, b_rd_t, b_rd_age}, exp_b.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        int bad_rdy;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_valid_mask", valid_mask, 0);
        chk("rst_stale_mask", stale_mask, 0);
        chk("rst_payload", {rd_hit, rd_x, rd_y, rd_z, rd_t, rd_age}, 0);
        chk("rst_b_valid_mask", b_valid_mask, 0);
        rst = 1'b0;
        step();
        chk("wr_ready_after_rst", wr_ready, 1);

        wr(4'd11, 8'h55, 8'hF0, 8'hAA, 8'hCC);
        rd(4'd11, ex(1, 8'h55, 8'hF0, 8'hAA, 8'hCC, 4'd0));

        wr_valid = 1'b1; wr_sel = 4'd11; wr_x = 8'h55; wr_y = 8'hD0; wr_z = 8'hAA; wr_t = 8'hCC;
        rd_req = 1'b1; rd_sel = 4'd11;
        exp_q.push_back(ex(1, 8'h55, 8'hF0, 8'hAA, 8'hCC, 4'd0));
        step();
        wr_valid = 1'b0; rd_req = 1'b0;
        rd(4'd11, ex(1, 8'h55, 8'hD0, 8'hAA, 8'hCC, 4'd0));
        rd(4'd5, ex(0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0));

        wr(4'd3, 8'h01, 8'h02, 8'h03, 8'h04);
        age_tick = 1'b1;
        repeat (14) step();
        age_tick = 1'b0;
        @(negedge clk);
        chk("stale3_after14", stale_mask[3], 0);
        age_tick = 1'b1;
        step();
        age_tick = 1'b0;
        @(negedge clk);
        chk("stale3_after15", stale_mask[3], 1);
        rd(4'd3, ex(1, 8'h01, 8'h02, 8'h03, 8'h04, 4'd15));
        age_tick = 1'b1;
        step();
        age_tick = 1'b0;
        rd(4'd3, ex(1, 8'h01, 8'h02, 8'h03, 8'h04, 4'd15));
        rd(4'd5, ex(0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0));
        age_tick = 1'b1;
        wr(4'd3, 8'h09, 8'h08, 8'h07, 8'h06);
        age_tick = 1'b0;
        @(negedge clk);
        chk("stale3_after_rewrite", stale_mask[3], 0);
        chk("stale11_saturated", stale_mask[11], 1);
        rd(4'd3, ex(1, 8'h09, 8'h08, 8'h07, 8'h06, 4'd0));

        for (int i = 0; i < 16; i++) wr(4'(i), 8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48));
        @(negedge clk);
        chk("all_valid", valid_mask, 16'hFFFF);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_n = 0;
        bad_rdy = 0;
        for (int c = 0; c < 40; c++) begin
            rd_req = c < 3;
            rd_sel = c == 2 ? 4'd0 : 4'd15;
            age_tick = c == 0;
            clr_req = c == 1;
            if (c == 0) exp_q.push_back(ex(1, 8'd15, 8'd31, 8'd47, 8'd63, 4'd0));
            if (c == 1) exp_q.push_back(ex(1, 8'd15, 8'd31, 8'd47, 8'd63, 4'd1));
            if (c == 2) exp_q.push_back(ex(0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0));
            @(negedge clk);
            if (!clr_busy) break;
            busy_n++;
            if (wr_ready) bad_rdy++;
            step();
        end
        rd_req = 1'b0; age_tick = 1'b0; clr_req = 1'b0;
        chk("sweep_cycles", busy_n, 16);
        chk("sweep_wr_ready_low", bad_rdy, 0);
        chk("sweep_valid_mask", valid_mask, 0);
        step();
        @(negedge clk);
        chk("sweep_no_restart", clr_busy, 0);

        wr(4'd2, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
        wr(4'd7, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (4) step();
        rd_req = 1'b1; rd_sel = 4'd7;
        step();
        rd_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_payload", {rd_hit, rd_x, rd_y, rd_z, rd_t, rd_age}, 0);
        chk("midrst_clr_busy", clr_busy, 0);
        chk("midrst_valid_mask", valid_mask, 0);
        chk("midrst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("midrst_wr_ready", wr_ready, 1);
        wr(4'd7, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
        @(negedge clk);
        chk("postrst_write", valid_mask, 16'h0080);
        rd(4'd7, ex(1, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 4'd0));

        b_wr_valid = 1'b1; b_wr_sel = 4'd2; b_wr_x = 8'h44;
        step();
        b_wr_valid = 1'b0;
        @(negedge clk);
        chk("b_err_inrange", b_err, 0);
        chk("b_mask_inrange", b_valid_mask, 12'h004);
        b_wr_valid = 1'b1; b_wr_sel = 4'd13; b_wr_x = 8'h77;
        step();
        b_wr_valid = 1'b0;
        @(negedge clk);
        chk("b_err_wr13", b_err, 1);
        chk("b_mask_wr13", b_valid_mask, 12'h004);
        @(negedge clk);
        chk("b_err_pulse_end", b_err, 0);
        b_rd_req = 1'b1; b_rd_sel = 4'd13;
        exp_b.push_back(ex(0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0));
        step();
        b_rd_req = 1'b0;
        @(negedge clk);
        chk("b_err_rd13", b_err, 1);
        b_rd_req = 1'b1; b_rd_sel = 4'd2;
        exp_b.push_back(ex(1, 8'h44, 8'h11, 8'h22, 8'h33, 4'd0));
        step();
        b_rd_req = 1'b0;

        repeat (3) step();
        chk("main_queue_drained", exp_q.size(), 0);
        chk("b_queue_drained", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/telem_track_file.md
TELEM_TRACK_FILE -- requirements
Module: telem_track_file

Interface
REQ-001 Parameter: NUM_TGT, 16, number of target entries (2..64).
REQ-002 Parameter: CRD_W, 8, width of each of the X, Y, Z and T coordinates.
REQ-003 Parameter: AGE_W, 4, width of the per-entry age counter.
REQ-004 Parameter: SEL_W, $clog2(NUM_TGT), target select width (derived).
REQ-005 clk  in  1  single system clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 wr_valid  in  1  write request.
REQ-008 wr_ready  out  1  write accepted when high together with wr_valid.
REQ-009 wr_sel  in  SEL_W  target index to write.
REQ-010 wr_x, wr_y, wr_z, wr_t  in  CRD_W each  coordinate payload.
REQ-011 rd_req  in  1  read request.
REQ-012 rd_sel  in  SEL_W  target index to read.
REQ-013 rd_valid  out  1  read data valid, one-cycle pulse.
REQ-014 rd_x, rd_y, rd_z, rd_t  out  CRD_W each  read payload.
REQ-015 rd_hit  out  1  the entry read was valid.
REQ-016 rd_age  out  AGE_W  age of the entry read.
REQ-017 age_tick  in  1  aging strobe.
REQ-018 clr_req  in  1  start a sequential clear sweep.
REQ-019 clr_busy  out  1  clear sweep in progress.
REQ-020 valid_mask, stale_mask  out  NUM_TGT each  per-entry valid and stale flags.
REQ-021 err  out  1  one-cycle pulse on an out-of-range index.

Function
REQ-022 Write: when wr_valid and wr_ready are high and wr_sel < NUM_TGT, the entry stores its payload at the clock edge, sets valid=1 and sets age=0.
REQ-023 wr_ready is high in IDLE and low in CLEAR.
REQ-024 Read latency is exactly 1 cycle: rd_req at edge N gives rd_valid plus data at edge N+1; outputs hold their last value when rd_valid=0.
REQ-025 Reading an entry with valid=0 returns rd_hit=0 and a payload of all zeros.
REQ-026 Read and write to the same index in the same cycle returns the old contents (read-before-write).
REQ-027 On age_tick, every valid entry's age increments and saturates at 2^AGE_W-1.
REQ-028 stale_mask[i] is high when valid[i] is high and age[i] is saturated.
REQ-029 A write together with age_tick to the same entry leaves age=0 (write wins).
REQ-030 An out-of-range wr_sel or rd_sel (>= NUM_TGT) has no state change, rd_hit=0 with a zero payload, and err=1 for one cycle.
REQ-031 FSM IDLE->CLEAR on clr_req; CLEAR holds a sweep index starting at 0.
REQ-032 In CLEAR, one entry per cycle is cleared (valid=0, age=0, data=0).
REQ-033 CLEAR->IDLE after clearing index NUM_TGT-1; the sweep takes exactly NUM_TGT cycles.
REQ-034 clr_busy is high in CLEAR.
REQ-035 In CLEAR, reads are still served and return the current entry contents.
REQ-036 clr_req received while already in CLEAR is ignored.
REQ-037 An age_tick during CLEAR ages only the entries that are still valid.

Reset
REQ-038 While rst is high, all entries and outputs are zero: valid=0, age=0, data=0, rd_valid=0, err=0, clr_busy=0, and the FSM is in IDLE.
REQ-039 Asserting rst mid-sweep or mid-read aborts the operation immediately.
REQ-040 After reset deasserts, wr_ready=1 on the first clock edge.

Structure
REQ-041 A shared package telem_pkg holds the FSM state enum (IDLE, CLEAR), the default parameter constants, and a coordinate record type (x, y, z, t).
REQ-042 One sub-module, telem_entry, holds a single entry (payload register, valid bit, saturating age counter); it is instantiated NUM_TGT times via a generate loop.

Verification
REQ-043 Reset, then write idx 11 with X=0x55 Y=0xF0 Z=0xAA T=0xCC, then read idx 11 -> next cycle rd_valid=1, rd_hit=1, payload matches, rd_age=0.
REQ-044 Overwrite idx 11 with Y=0xD0 while reading idx 11 in the same cycle -> old Y=0xF0 returned; a read on the following cycle returns 0xD0.
REQ-045 With AGE_W=4, write idx 3, then apply 15 age_tick pulses -> stale_mask[3]=1, rd_age=15; a 16th tick leaves rd_age=15; a rewrite clears stale_mask[3].
REQ-046 With entries 0..15 valid, pulse clr_req -> clr_busy high for 16 cycles, wr_ready=0 during the sweep, valid_mask reaches 0 in that time, and clr_busy then drops.
REQ-047 NUM_TGT=12, write to idx 13 -> err pulse and valid_mask unchanged; read idx 13 -> rd_hit=0 and a zero payload.
REQ-048 Assert rst at the 5th sweep cycle -> all outputs zero, the FSM in IDLE, and wr_ready=1 after release.
